// File: rtl/roce_qp_pkg.sv
// Shared types and helpers for the RoCE QP context table.
package roce_qp_pkg;

  localparam int unsigned QPN_W  = 24;
  localparam int unsigned PSN_W  = 24;
  localparam int unsigned RKEY_W = 32;
  localparam int unsigned IP_W   = 32;
  localparam int unsigned ADDR_W = 64;

  // Upper QPN bits that every locally owned QPN must carry
  localparam logic [15:0] QPN_BASE = 16'd1;

  typedef enum logic [2:0] {
    QP_INIT  = 3'd0,
    QP_RTR   = 3'd1,
    QP_RTS   = 3'd2,
    QP_ERROR = 3'd3
  } qp_state_e;

  typedef struct packed {
    qp_state_e           state;
    logic [RKEY_W-1:0]   r_key;
    logic [QPN_W-1:0]    rem_qpn;
    logic [QPN_W-1:0]    loc_qpn;
    logic [PSN_W-1:0]    rem_psn;
    logic [PSN_W-1:0]    loc_psn;
    logic [IP_W-1:0]     rem_ip_addr;
    logic [ADDR_W-1:0]   rem_addr;
  } qp_ctx_t;

  // Reset / empty context: ERROR with every field cleared
  function automatic qp_ctx_t qp_ctx_reset();
    qp_ctx_t c;
    c       = '0;
    c.state = QP_ERROR;
    return c;
  endfunction

  // INIT->RTR, RTR->RTS, any other state->ERROR; everything else rejected
  function automatic logic qp_transition_legal(input qp_state_e cur, input logic [2:0] nxt);
    logic ok;
    ok = 1'b0;
    case (nxt)
      3'd1:    ok = (cur == QP_INIT);
      3'd2:    ok = (cur == QP_RTR);
      3'd3:    ok = (cur != QP_ERROR);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/roce_qpn_range_check.sv
// Combinational QPN decode: flags whether a QPN maps to a local slot and
// extracts the slot index.
module roce_qpn_range_check
  import roce_qp_pkg::*;
#(
  parameter  int unsigned MAX_QUEUE_PAIRS = 4,
  localparam int unsigned IDX_W           = $clog2(MAX_QUEUE_PAIRS)
) (
  input  logic [QPN_W-1:0] qpn,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Shifting the low byte avoids an empty slice when 256 slots are configured
  always_comb begin
    valid = (qpn[QPN_W-1:8] == QPN_BASE) && ((qpn[7:0] >> IDX_W) == 8'd0);
    idx   = qpn[IDX_W-1:0];
  end

endmodule

// File: rtl/roce_qp_context_table.sv
// Per-QP context store: open/modify/PSN-advance writes with QP state machine
// enforcement, and a one-cycle registered context query.
// Optional feature macro: ROCE_QP_CTX_QUERY_COUNT_EN (per-slot RTS query counter).
module roce_qp_context_table
  import roce_qp_pkg::*;
#(
  parameter int unsigned MAX_QUEUE_PAIRS = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 s_qp_context_req,
  input  logic [QPN_W-1:0]     s_qp_local_qpn_req,

  output logic                 m_qp_context_valid,
  output logic [2:0]           m_qp_state,
  output logic [RKEY_W-1:0]    m_qp_r_key,
  output logic [QPN_W-1:0]     m_qp_rem_qpn,
  output logic [QPN_W-1:0]     m_qp_loc_qpn,
  output logic [PSN_W-1:0]     m_qp_rem_psn,
  output logic [PSN_W-1:0]     m_qp_loc_psn,
  output logic [IP_W-1:0]      m_qp_rem_ip_addr,
  output logic [ADDR_W-1:0]    m_qp_rem_addr,

  input  logic                 s_open_valid,
  input  logic [QPN_W-1:0]     s_open_loc_qpn,
  input  logic [QPN_W-1:0]     s_open_rem_qpn,
  input  logic [PSN_W-1:0]     s_open_rem_psn,
  input  logic [PSN_W-1:0]     s_open_loc_psn,
  input  logic [RKEY_W-1:0]    s_open_r_key,
  input  logic [IP_W-1:0]      s_open_rem_ip_addr,
  input  logic [ADDR_W-1:0]    s_open_rem_addr,

  input  logic                 s_modify_valid,
  input  logic [QPN_W-1:0]     s_modify_loc_qpn,
  input  logic [2:0]           s_modify_state,

  input  logic                 s_psn_adv_valid,
  input  logic [QPN_W-1:0]     s_psn_adv_loc_qpn,
  input  logic [PSN_W-1:0]     s_psn_adv_count,

`ifdef ROCE_QP_CTX_QUERY_COUNT_EN
  output logic [31:0]          m_qp_query_count,
`endif
  output logic                 m_cfg_err
);

  localparam int unsigned IDX_W = $clog2(MAX_QUEUE_PAIRS);

  qp_ctx_t slot_q [MAX_QUEUE_PAIRS];
  qp_ctx_t slot_d [MAX_QUEUE_PAIRS];
  qp_ctx_t resp_q, resp_d;
  logic    resp_valid_q, resp_valid_d;
  logic    cfg_err_q, cfg_err_d;

  logic             qry_ok, open_ok, mod_ok, adv_ok;
  logic [IDX_W-1:0] qry_idx, open_idx, mod_idx, adv_idx;

  logic open_apply, open_err;
  logic mod_hit, mod_blocked, mod_apply, mod_err;
  logic adv_hit, adv_blocked, adv_apply, adv_err;

  roce_qpn_range_check #(.MAX_QUEUE_PAIRS(MAX_QUEUE_PAIRS)) u_chk_qry (
    .qpn(s_qp_local_qpn_req), .valid(qry_ok), .idx(qry_idx)
  );
  roce_qpn_range_check #(.MAX_QUEUE_PAIRS(MAX_QUEUE_PAIRS)) u_chk_open (
    .qpn(s_open_loc_qpn), .valid(open_ok), .idx(open_idx)
  );
  roce_qpn_range_check #(.MAX_QUEUE_PAIRS(MAX_QUEUE_PAIRS)) u_chk_mod (
    .qpn(s_modify_loc_qpn), .valid(mod_ok), .idx(mod_idx)
  );
  roce_qpn_range_check #(.MAX_QUEUE_PAIRS(MAX_QUEUE_PAIRS)) u_chk_adv (
    .qpn(s_psn_adv_loc_qpn), .valid(adv_ok), .idx(adv_idx)
  );

  // Arbitrate same-slot requests (open > modify > PSN advance) and flag rejects.
  // A lower-priority request loses to any valid-QPN request on the same slot,
  // whether or not the winner itself is accepted by the state machine.
  always_comb begin
    open_apply  = s_open_valid && open_ok;
    open_err    = s_open_valid && !open_ok;

    mod_hit     = s_modify_valid && mod_ok;
    mod_blocked = mod_hit && open_apply && (mod_idx == open_idx);
    mod_apply   = mod_hit && !mod_blocked &&
                  qp_transition_legal(slot_q[mod_idx].state, s_modify_state);
    mod_err     = s_modify_valid && !mod_apply;

    adv_hit     = s_psn_adv_valid && adv_ok;
    adv_blocked = adv_hit && ((open_apply && (adv_idx == open_idx)) ||
                              (mod_hit && (adv_idx == mod_idx)));
    adv_apply   = adv_hit && !adv_blocked && (slot_q[adv_idx].state == QP_RTS);
    adv_err     = s_psn_adv_valid && !adv_apply;

    cfg_err_d   = open_err || mod_err || adv_err;
  end

  // Next slot contents; arbitration above guarantees at most one write per slot
  always_comb begin
    slot_d = slot_q;
    if (adv_apply) begin
      slot_d[adv_idx].rem_psn = slot_q[adv_idx].rem_psn + s_psn_adv_count;
    end
    if (mod_apply) begin
      slot_d[mod_idx].state = qp_state_e'(s_modify_state);
    end
    if (open_apply) begin
      slot_d[open_idx].state       = QP_INIT;
      slot_d[open_idx].r_key       = s_open_r_key;
      slot_d[open_idx].rem_qpn     = s_open_rem_qpn;
      slot_d[open_idx].loc_qpn     = s_open_loc_qpn;
      slot_d[open_idx].rem_psn     = s_open_rem_psn;
      slot_d[open_idx].loc_psn     = s_open_loc_psn;
      slot_d[open_idx].rem_ip_addr = s_open_rem_ip_addr;
      slot_d[open_idx].rem_addr    = s_open_rem_addr;
    end
  end

  // Query response from pre-update contents; fields hold when idle
  always_comb begin
    resp_valid_d = s_qp_context_req;
    resp_d       = resp_q;
    if (s_qp_context_req) begin
      resp_d = qry_ok ? slot_q[qry_idx] : qp_ctx_reset();
    end
  end

  // Slot, response and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_QUEUE_PAIRS; i++) begin
        slot_q[i] <= qp_ctx_reset();
      end
      resp_q       <= qp_ctx_reset();
      resp_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign m_qp_context_valid = resp_valid_q;
  assign m_qp_state         = resp_q.state;
  assign m_qp_r_key         = resp_q.r_key;
  assign m_qp_rem_qpn       = resp_q.rem_qpn;
  assign m_qp_loc_qpn       = resp_q.loc_qpn;
  assign m_qp_rem_psn       = resp_q.rem_psn;
  assign m_qp_loc_psn       = resp_q.loc_psn;
  assign m_qp_rem_ip_addr   = resp_q.rem_ip_addr;
  assign m_qp_rem_addr      = resp_q.rem_addr;
  assign m_cfg_err          = cfg_err_q;

`ifdef ROCE_QP_CTX_QUERY_COUNT_EN
  logic [31:0] qcnt_q [MAX_QUEUE_PAIRS];
  logic [31:0] qcnt_d [MAX_QUEUE_PAIRS];
  logic [31:0] qcnt_resp_q, qcnt_resp_d;

  // Count RTS queries per slot; open clears, response carries pre-increment value
  always_comb begin
    qcnt_d      = qcnt_q;
    qcnt_resp_d = qcnt_resp_q;
    if (s_qp_context_req) begin
      qcnt_resp_d = qry_ok ? qcnt_q[qry_idx] : '0;
      if (qry_ok && (slot_q[qry_idx].state == QP_RTS)) begin
        qcnt_d[qry_idx] = qcnt_q[qry_idx] + 32'd1;
      end
    end
    if (open_apply) begin
      qcnt_d[open_idx] = '0;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_QUEUE_PAIRS; i++) begin
        qcnt_q[i] <= '0;
      end
      qcnt_resp_q <= '0;
    end else begin
      qcnt_q      <= qcnt_d;
      qcnt_resp_q <= qcnt_resp_d;
    end
  end

  assign m_qp_query_count = qcnt_resp_q;
`endif

endmodule
